mdu_ctrl: RTL
=============

# mdu_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline, placed in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo operations, runs them for a fixed multi-cycle latency, and owns the architectural HI/LO registers. It raises a busy flag and a D-stage stall request so the hazard unit can hold any MDU-class instruction (including mfhi/mflo) until the results are valid.

## Interface

Parameters:
- MULT_CYCLES, 5: busy duration for mult/multu, ≥1
- DIV_CYCLES, 10: busy duration for div/divu, ≥1

Ports:
- clk  input  1  pipeline clock; single clock domain
- reset  input  1  synchronous, active-high
- start  input  1  E-stage instruction is an MDU operation and is valid this cycle
- op  input  3  operation code from shared package (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO)
- a  input  32  forwarded rs value from E
- b  input  32  forwarded rt value from E
- mdu_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- hi  output  32  architectural HI, read by mfhi
- lo  output  32  architectural LO, read by mflo
- busy  output  1  multi-cycle operation in flight
- stall_md  output  1  stall request ORed into the hazard unit's stall

## Operation

- Reset: state IDLE, counter 0, hi = lo = 0, busy = 0, stall_md = 0.
- States: IDLE, MUL, DIV.
- IDLE:
  - start && op ∈ {MULT, MULTU}: latch a and b, load counter = MULT_CYCLES, go to MUL.
  - start && op ∈ {DIV, DIVU}: latch a and b, load counter = DIV_CYCLES, go to DIV.
  - start && op == MTHI: hi ← a at this edge; stay IDLE.
  - start && op == MTLO: lo ← a at this edge; stay IDLE.
  - op == NONE: no action.
- MUL/DIV:
  - Counter decrements at each edge.
  - At the edge where counter == 1: write hi/lo, go to IDLE.
  - start is ignored while busy; no latch and no HI/LO write. The stall contract guarantees it never arrives; the bench asserts it.
- Arithmetic:
  - MULT: {hi, lo} = signed 64-bit a×b.
  - MULTU: {hi, lo} = unsigned 64-bit a×b.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divisor 0 (DIV or DIVU): hi/lo unchanged, full DIV_CYCLES latency still spent.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Outputs:
  - busy = (state != IDLE).
  - stall_md = mdu_use_D && (busy || (start && op ∈ {MULT, MULTU, DIV, DIVU})). Combinational.
- Reset mid-operation: abort immediately; IDLE with hi = lo = 0 after the reset edge, and the in-flight result is discarded.

## Timing

- start sampled at edge k: busy = 1 in cycles k+1 … k+N (N = MULT_CYCLES or DIV_CYCLES).
- hi/lo updated at edge k+N, so new values are visible in the same cycle that busy returns to 0.
- A new start is accepted in the first cycle with busy = 0 (back-to-back issue allowed).
- mthi/mtlo: one-cycle effect, value visible the cycle after start; busy never asserts.
- stall_md has zero latency (combinational from start, op, mdu_use_D and state). An MDU instruction in D in the start cycle is therefore held for N+1 cycles total.
- No combinational path from a or b to any output.

## Structure

- Shared package (alongside existing opcode/funct constants): MDU op encoding (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6), state encoding (IDLE, MUL, DIV), default latencies.
- The decode of instr → op and mdu_use_D belongs in the existing controller, not in this block.
- One sub-module: mdu_arith. It is combinational 64-bit product and quotient/remainder on the latched operands, including the divide-by-zero and overflow rules. mdu_ctrl contains only the FSM, counter, operand latches and HI/LO registers.

## Test plan

- MULT a=0xFFFFFFFF b=0x00000002 → busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU a=0xFFFFFFFF b=0x00000002 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV a=0xFFFFFFF9 (−7) b=2 → busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 → hi/lo unchanged, busy still 10 cycles.
- mdu_use_D=1 during the start cycle and all busy cycles of a MULT → stall_md=1 for 6 cycles, 0 on the cycle busy falls; mfhi issued then reads the new hi.
- MTHI a=0x00001234 while idle → hi=0x00001234 next cycle, busy stays 0; MTLO back-to-back → lo updated, hi retained.
- reset asserted in the 4th busy cycle of DIV → next cycle busy=0, hi=lo=0, state IDLE; a MULT started the following cycle completes normally.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: operation encoding, controller states and default latencies.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } mdu_state_e;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    // Operations that occupy the unit for more than one cycle.
    function automatic logic is_long_op(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product and quotient/remainder on the latched MDU operands.
module mdu_arith (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        is_div_i,
    input  logic        is_signed_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        wr_o
);

    logic        neg_a;
    logic        neg_b;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] dvs;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        neg_a = is_signed_i & a_i[31];
        neg_b = is_signed_i & b_i[31];

        // Low 64 bits of the product of sign/zero-extended operands give both MULT and MULTU.
        a_ext = {{32{neg_a}}, a_i};
        b_ext = {{32{neg_b}}, b_i};
        prod  = a_ext * b_ext;

        // Magnitude divide; 0x80000000 maps onto itself, so its unsigned magnitude stays exact.
        a_mag = neg_a ? (~a_i + 32'd1) : a_i;
        b_mag = neg_b ? (~b_i + 32'd1) : b_i;
        dvs   = (b_i == '0) ? 32'd1 : b_mag;
        q_mag = a_mag / dvs;
        r_mag = a_mag % dvs;

        hi_o = prod[63:32];
        lo_o = prod[31:0];
        wr_o = 1'b1;
        if (is_div_i) begin
            lo_o = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
            hi_o = neg_a ? (~r_mag + 32'd1) : r_mag;
            wr_o = (b_i != '0);
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: FSM, latency counter, operand latches and architectural HI/LO.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mdu_use_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    mdu_op_e    op_e;
    mdu_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        signed_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    assign op_e = mdu_op_e'(op);

    mdu_arith u_arith (
        .a_i        (a_q),
        .b_i        (b_q),
        .is_div_i   (state_q == ST_DIV),
        .is_signed_i(signed_q),
        .hi_o       (res_hi),
        .lo_o       (res_lo),
        .wr_o       (res_wr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        unique case (op_e)
                            MDU_MULT, MDU_MULTU: begin
                                a_q      <= a;
                                b_q      <= b;
                                signed_q <= (op_e == MDU_MULT);
                                cnt_q    <= CW'(MULT_CYCLES);
                                state_q  <= ST_MUL;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                a_q      <= a;
                                b_q      <= b;
                                signed_q <= (op_e == MDU_DIV);
                                cnt_q    <= CW'(DIV_CYCLES);
                                state_q  <= ST_DIV;
                            end
                            MDU_MTHI: hi_q <= a;
                            MDU_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    // start is deliberately ignored here; the stall keeps new MDU ops out.
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        if (res_wr) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != ST_IDLE);
    assign stall_md = mdu_use_D && (busy || (start && is_long_op(op_e)));

endmodule
